// File: rtl/keccak_pad_absorb_if.sv
// keccak_pad_absorb_if
// Groups the message-lane handshake and the rate-block handshake of keccak_pad_absorb into a
// single bundle.
//
// Modports:
//   slave  - the padding stage's view. It receives lanes and produces blocks.
//   master - the environment's view. It produces lanes and consumes blocks.
//
// Signals:
//   in_valid/in_ready           message lane handshake
//   in_data [N]                 message lane, little-endian (byte 0 = bits 7:0)
//   in_last, in_bytes [4]       final-lane marker and its valid byte count (0..8)
//   blk_valid/blk_ready         rate block handshake
//   blk_data [RATE_LANES*N]     rate block, lane i at [i*N +: N]
//   blk_last                    block is the final padded block of the message
//   in_xof                      only present when KECCAK_PAD_XOF_EN is defined
interface keccak_pad_absorb_if #(
    parameter int unsigned RATE_LANES = 17,
    parameter int unsigned N          = 64
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N-1:0]            in_data;
    logic                    in_last;
    logic [3:0]              in_bytes;
    logic                    blk_valid;
    logic                    blk_ready;
    logic [RATE_LANES*N-1:0] blk_data;
    logic                    blk_last;
`ifdef KECCAK_PAD_XOF_EN
    logic                    in_xof;

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, in_xof, blk_ready,
        output in_ready, blk_valid, blk_data, blk_last
    );
    modport master (
        output in_valid, in_data, in_last, in_bytes, in_xof, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_last
    );
`else
    modport slave (
        input  in_valid, in_data, in_last, in_bytes, blk_ready,
        output in_ready, blk_valid, blk_data, blk_last
    );
    modport master (
        output in_valid, in_data, in_last, in_bytes, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_last
    );
`endif
endinterface

// File: rtl/keccak_pad_absorb.sv
// keccak_pad_absorb
// Input-side stage in front of the Keccak-f[1600] permutation. It collects 64-bit message lanes
// into a rate block and applies SHA-3 multi-rate padding. The domain byte follows the last
// message byte, and 0x80 is set in the final rate byte. Each full block is then presented to the
// absorb stage.
//
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - keccak_pad_absorb_if.slave (lane input handshake, block output handshake)
//
// Optional feature (macro KECCAK_PAD_XOF_EN):
//   Adds bus.in_xof. It is sampled with the first lane of a message.
//   in_xof = 1 selects the SHAKE domain byte 8'h1F; otherwise DSBYTE is used.
module keccak_pad_absorb #(
    parameter int unsigned RATE_LANES = 17,
    parameter int unsigned N          = 64,
    parameter logic [7:0]  DSBYTE     = 8'h06
) (
    input  logic          clk,
    input  logic          rst,
    keccak_pad_absorb_if.slave bus
);
    localparam int unsigned BlkW     = RATE_LANES * N;
    localparam int unsigned NumBytes = N / 8;
    localparam int unsigned CntW     = 5;
    localparam logic [CntW-1:0] LastIdx = CntW'(RATE_LANES - 1);
    // Top bit of byte 7 of the last rate lane: the 0x80 end-of-padding marker.
    localparam int unsigned PadBit   = BlkW - 1;

    typedef enum logic [1:0] {StFill, StOut, StPad} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BlkW-1:0]   buf_q, buf_d;
    logic              last_q, last_d;
    logic              pend_q, pend_d;

    logic              in_ready;
    logic              blk_valid;
    logic [3:0]        k;
    logic [N-1:0]      keep_mask;
    logic [N-1:0]      lane;
    logic [CntW-1:0]   nxt_idx;
    logic [7:0]        ds_fill;
    logic [7:0]        ds_pad;

`ifdef KECCAK_PAD_XOF_EN
    logic              xof_q, xof_d;
    logic              in_msg_q, in_msg_d;
    logic              xof_eff;

    // The mode is taken from the first lane of a message and held until the message completes.
    always_comb begin
        xof_eff = xof_q;
        if (cnt_q == '0 && !in_msg_q) begin
            xof_eff = bus.in_xof;
        end
    end

    assign ds_fill = xof_eff ? 8'h1F : DSBYTE;
    assign ds_pad  = xof_q   ? 8'h1F : DSBYTE;
`else
    assign ds_fill = DSBYTE;
    assign ds_pad  = DSBYTE;
`endif

    // The lane after the current one. It is only used when that lane exists.
    assign nxt_idx = (cnt_q == LastIdx) ? cnt_q : cnt_q + 5'd1;

    always_comb begin
        k = (bus.in_bytes > 4'd8) ? 4'd8 : bus.in_bytes;
        keep_mask = '0;
        for (int b = 0; b < NumBytes; b++) begin
            keep_mask[b*8 +: 8] = (b < int'(k)) ? 8'hFF : 8'h00;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        last_d    = last_q;
        pend_d    = pend_q;
        in_ready  = 1'b0;
        blk_valid = 1'b0;
        lane      = bus.in_data & keep_mask;
`ifdef KECCAK_PAD_XOF_EN
        xof_d     = xof_q;
        in_msg_d  = in_msg_q;
`endif
        unique case (state_q)
            StFill: begin
                // While reset is held the stage must not advertise readiness.
                in_ready = !rst;
                if (bus.in_valid && in_ready) begin
`ifdef KECCAK_PAD_XOF_EN
                    xof_d    = xof_eff;
                    in_msg_d = !bus.in_last;
`endif
                    if (!bus.in_last) begin
                        buf_d[32'(cnt_q)*N +: N] = bus.in_data;
                        if (cnt_q == LastIdx) begin
                            cnt_d   = '0;
                            last_d  = 1'b0;
                            state_d = StOut;
                        end else begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = StOut;
                        if (k != 4'd8) begin
                            // The domain byte lands right after the last message byte. The 0x80
                            // is OR-ed afterwards, so the two merge if they share a byte.
                            lane = lane ^ ({{(N-8){1'b0}}, ds_fill} << (8 * k));
                            buf_d[32'(cnt_q)*N +: N] = lane;
                            buf_d[PadBit] = 1'b1;
                            last_d = 1'b1;
                        end else if (cnt_q != LastIdx) begin
                            buf_d[32'(cnt_q)*N +: N]   = lane;
                            buf_d[32'(nxt_idx)*N +: N] = {{(N-8){1'b0}}, ds_fill};
                            buf_d[PadBit] = 1'b1;
                            last_d = 1'b1;
                        end else begin
                            // The message fills the block exactly. The padding therefore needs
                            // a block of its own.
                            buf_d[32'(cnt_q)*N +: N] = lane;
                            last_d = 1'b0;
                            pend_d = 1'b1;
                        end
                    end
                end
            end
            StOut: begin
                blk_valid = 1'b1;
                if (bus.blk_ready) begin
                    if (pend_q) begin
                        state_d = StPad;
                    end else begin
                        buf_d   = '0;
                        state_d = StFill;
                    end
                end
            end
            StPad: begin
                buf_d         = '0;
                buf_d[7:0]    = ds_pad;
                buf_d[PadBit] = 1'b1;
                last_d        = 1'b1;
                pend_d        = 1'b0;
                state_d       = StOut;
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StFill;
            cnt_q    <= '0;
            buf_q    <= '0;
            last_q   <= 1'b0;
            pend_q   <= 1'b0;
`ifdef KECCAK_PAD_XOF_EN
            xof_q    <= 1'b0;
            in_msg_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
`ifdef KECCAK_PAD_XOF_EN
            xof_q    <= xof_d;
            in_msg_q <= in_msg_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.blk_valid = blk_valid;
    assign bus.blk_data  = buf_q;
    assign bus.blk_last  = last_q;
endmodule

// File: doc/keccak_pad_absorb.md
Name: keccak_pad_absorb

Overview:
- Input-side stage in front of the Keccak-f[1600] permutation core.
- Accepts a message stream as 64-bit lanes with a valid/ready handshake and applies SHA-3 multi-rate padding (domain byte, then 0x80 in the final rate byte).
- Presents one full rate block at a time to the absorb/permutation stage, which XORs it into state lanes [y][x] in lane-index order i = 5*y + x.

Parameters:
- RATE_LANES, 17, lanes per rate block (17 = SHA3-256); legal range 1..21.
- N, 64, lane width in bits; fixed, matches the keccak_pkg lane width.
- DSBYTE, 8'h06, domain-separation byte inserted after the last message byte.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  message lane valid.
- in_ready  output  1  stage can accept a lane.
- in_data  input  N  message lane, little-endian: byte 0 = bits 7:0.
- in_last  input  1  lane is the final one of the message.
- in_bytes  input  4  valid bytes in the last lane (0..8); ignored when in_last=0.
- blk_valid  output  1  rate block available.
- blk_ready  input  1  permutation stage accepts the block.
- blk_data  output  RATE_LANES*N  rate block; lane i at bits [i*N +: N].
- blk_last  output  1  block is the final (padded) block of the message.

Behaviour:
- Reset values: in_ready=0, blk_valid=0, blk_last=0, blk_data=0, lane counter=0, pad_pending=0, state=FILL.
- FILL state:
  - in_ready=1, blk_valid=0.
  - Accept when in_valid & in_ready.
  - A non-last lane is stored at lane[cnt], then cnt++.
  - When cnt==RATE_LANES-1 is accepted as non-last, go to OUT with blk_last=0 and cnt=0.
- Accepted last lane, k = in_bytes:
  - Bytes 0..k-1 are kept; bytes >= k are forced to 0.
  - If k<8: byte k ^= DSBYTE, byte 7 of lane RATE_LANES-1 |= 0x80, go to OUT with blk_last=1.
  - If k==8 and cnt<RATE_LANES-1: DSBYTE is written to byte 0 of lane cnt+1, byte 7 of the last lane |= 0x80, go to OUT with blk_last=1.
  - If k==8 and cnt==RATE_LANES-1: the block is full, so go to OUT with blk_last=0 and set pad_pending=1.
  - Coincident bytes merge: DSBYTE and 0x80 in the same byte give 0x86.
  - in_bytes > 8 is treated as 8.
- OUT state:
  - in_ready=0, blk_valid=1.
  - blk_data and blk_last are held stable until blk_ready.
  - On handshake, if pad_pending=1: go to PAD.
  - Otherwise clear the buffer to 0 and go to FILL.
- PAD state (1 cycle):
  - Buffer = DSBYTE in lane 0 byte 0, 0x80 in lane RATE_LANES-1 byte 7, all else 0.
  - blk_last=1, pad_pending=0, then go to OUT.
- Latency:
  - blk_valid rises the cycle after the accepting edge of the completing lane.
  - In the pad_pending case, the padding-only block appears 2 cycles after the first block's handshake.
- Throughput: one lane per cycle in FILL; no lane is accepted during OUT or PAD.
- in_valid=0 mid-block: the counter and buffer hold indefinitely.
- Reset in any state: the partial block and pad_pending are discarded; outputs take reset values on the next edge.
- blk_ready asserted with blk_valid=0 has no effect.

Optional Feature:
- Macro: KECCAK_PAD_XOF_EN.
- When defined:
  - Adds input port in_xof (1 bit), sampled with the first accepted lane of each message (cnt==0 and no message in progress) and held until the message completes.
  - in_xof=1 uses domain byte 8'h1F (SHAKE); in_xof=0 uses DSBYTE.
- When undefined: the port is absent and DSBYTE is always used.

Test Plan:
- Empty message (RATE_LANES=17): one lane, in_last=1, in_bytes=0 -> blk_data lane0=64'h06, lane16=64'h8000_0000_0000_0000, other lanes 0, blk_last=1, blk_valid 1 cycle after accept.
- "abc": in_data=64'hFFFF_FFFF_FF63_6261, in_bytes=3, in_last=1 -> lane0=64'h0000_0000_0663_6261, lane16=64'h8000_0000_0000_0000, blk_last=1.
- 16 full lanes, then a 17th lane with in_bytes=7 -> lane16 byte7=8'h86 (0x06|0x80), single block, blk_last=1.
- 17 full lanes, last has in_bytes=8 -> block 1 is the raw data with blk_last=0; after handshake, block 2 has lane0=64'h06, lane16=64'h8000_0000_0000_0000, blk_last=1; in_ready stays 0 until block 2 handshake.
- Backpressure: hold blk_ready=0 for 5 cycles with blk_valid=1 -> blk_data/blk_last stable, in_ready=0; accept on cycle 6, in_ready=1 the next cycle.
- Reset mid-fill after 5 lanes, then the "abc" message -> all outputs at reset values, result identical to the "abc" scenario (no stale lanes 1..4).
